// File: rtl/dmem_responder.sv
// Memory-side responder for the MEM-stage load/store interface.
// Each request runs LATENCY wait states and is serviced on the edge into RESP.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        RespValid,
  output logic        AddrErr
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT4    = 4'(LATENCY);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          load_q, load_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          addr_err_q, addr_err_d;

  logic          req;
  logic          req_err;
  logic          do_access;
  logic          acc_load;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic          mem_we;

  // Backing store is not touched by reset; zero at time 0 for simulation.
  logic [31:0]   mem [DEPTH_WORDS] = '{default: '0};

  assign req     = MemRead | MemWrite;
  assign req_err = (Address[1:0] != 2'b00)
                || ({2'b00, Address[31:2]} >= DEPTH_U)
                || (MemRead && MemWrite);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_d       = load_q;
    err_d        = err_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    Stall        = 1'b0;
    do_access    = 1'b0;
    acc_load     = load_q;
    acc_err      = err_q;
    acc_idx      = idx_q;
    acc_wdata    = wdata_q;
    mem_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          Stall   = 1'b1;
          load_d  = MemRead;
          err_d   = req_err;
          idx_d   = Address[AW+1:2];
          wdata_d = WriteData;
          cnt_d   = LAT4;
          if (LAT4 == 4'd0) begin
            // Zero latency: the access uses the live request, not the latch.
            state_d   = RESP;
            do_access = 1'b1;
            acc_load  = MemRead;
            acc_err   = req_err;
            acc_idx   = Address[AW+1:2];
            acc_wdata = WriteData;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        Stall = 1'b1;
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d   = RESP;
          do_access = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_access) begin
      resp_valid_d = 1'b1;
      addr_err_d   = acc_err;
      if (acc_err) begin
        if (acc_load) rdata_d = '0;
      end else if (acc_load) begin
        rdata_d = mem[acc_idx];
      end else begin
        mem_we = ~rst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      load_q       <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_q       <= load_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  assign ReadData  = rdata_q;
  assign RespValid = resp_valid_q;
  assign AddrErr   = addr_err_q;

endmodule
